down_counter: RTL and testbench

DOWN_COUNTER -- requirements
Module: down_counter

---
 rtl/counter_pkg.sv | 22 ++
 rtl/jk_ff_ar.sv | 29 ++
 rtl/down_counter.sv | 128 ++++++++++++
 tb/tb_down_counter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg
// Shared definitions for the down counter: FSM state encodings and a
// small helper used to build the per-bit J/K drive when a value has to
// be forced into the counter (load, reload or clear).
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 16;

  // Forcing a JK flip-flop to a value v needs J=v, K=~v; this packs
  // both vectors side by side as {J, K} for a 16-bit-wide value.
  function automatic logic [2*MAX_WIDTH-1:0] jk_force(input logic [MAX_WIDTH-1:0] value);
    return {value, ~value};
  endfunction

endpackage

// File: rtl/jk_ff_ar.sv
// jk_ff_ar
// JK flip-flop with asynchronous active-low clear.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous clear, active low (q goes to 0)
//   j, k  - JK controls: 00 hold, 01 reset, 10 set, 11 toggle
//   q     - stored bit
module jk_ff_ar (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/down_counter.sv
// down_counter
// Presettable down counter with one-shot and auto-reload modes. The
// count itself lives in a bank of JK flip-flops; an IDLE/RUN/DONE FSM
// decides each cycle whether the bank loads, decrements, reloads or
// clears.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   load  - synchronous load of d into count and preset (highest priority)
//   d     - preset value
//   en    - count enable
//   mode  - 0 one-shot, 1 auto-reload (sampled at the terminal event)
//   q     - current count
//   tc    - registered one-cycle pulse after each terminal event
//   busy  - state is RUN
//   done  - state is DONE
module down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] preset;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic [WIDTH-1:0] borrow;
  logic             tc_next;
  logic             terminal;

  logic [2*MAX_WIDTH-1:0] jk_load;
  logic [2*MAX_WIDTH-1:0] jk_reload;

  // Bit i toggles on a decrement exactly when every lower bit is zero.
  assign borrow[0] = 1'b1;
  for (genvar gi = 1; gi < WIDTH; gi++) begin : g_borrow
    assign borrow[gi] = ~|count[gi-1:0];
  end

  for (genvar gb = 0; gb < WIDTH; gb++) begin : g_bit
    jk_ff_ar u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (j_vec[gb]),
      .k     (k_vec[gb]),
      .q     (count[gb])
    );
  end

  assign terminal  = (count == WIDTH'(1));
  assign jk_load   = jk_force(MAX_WIDTH'(d));
  assign jk_reload = jk_force(MAX_WIDTH'(preset));

  // Next-state and JK drive. Load wins over everything; a terminal
  // event either reloads the preset or clears into DONE. In IDLE and
  // DONE the bank is held at zero so en can never disturb it.
  always_comb begin
    next_state = state;
    j_vec      = '0;
    k_vec      = '0;
    tc_next    = 1'b0;
    if (load) begin
      j_vec      = jk_load[MAX_WIDTH +: WIDTH];
      k_vec      = jk_load[0 +: WIDTH];
      next_state = (d != '0) ? RUN : IDLE;
    end else begin
      case (state)
        RUN: begin
          if (en) begin
            if (terminal) begin
              tc_next = 1'b1;
              if (mode) begin
                j_vec = jk_reload[MAX_WIDTH +: WIDTH];
                k_vec = jk_reload[0 +: WIDTH];
              end else begin
                k_vec      = '1;
                next_state = DONE;
              end
            end else begin
              j_vec = borrow;
              k_vec = borrow;
            end
          end
        end
        IDLE, DONE: begin
          k_vec = '1;
        end
        default: begin
          k_vec      = '1;
          next_state = IDLE;
        end
      endcase
    end
  end

  // State, preset and terminal-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      preset <= '0;
      tc     <= 1'b0;
    end else begin
      state <= next_state;
      tc    <= tc_next;
      if (load) begin
        preset <= d;
      end
    end
  end

  assign q    = count;
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter
// Self-checking bench for down_counter: directed scenarios with literal
// expectations plus randomized stimulus compared every cycle against a
// behavioural model of the counter.
module tb_down_counter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             en;
  logic             mode;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;
  logic             done;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: plain count value, stored preset and two flags.
  int m_q      = 0;
  int m_preset = 0;
  bit m_run    = 0;
  bit m_exp    = 0;
  bit m_tc     = 0;

  down_counter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .d     (d),
    .en    (en),
    .mode  (mode),
    .q     (q),
    .tc    (tc),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model reset: takes effect the moment rst_n falls.
  always @(negedge rst_n) begin
    m_q = 0; m_preset = 0; m_run = 0; m_exp = 0; m_tc = 0;
  end

  // Model update on each rising edge from the inputs held before it.
  always @(posedge clk) begin
    bit pulse;
    pulse = 0;
    if (!rst_n) begin
      m_q = 0; m_preset = 0; m_run = 0; m_exp = 0;
    end else if (load) begin
      m_q = int'(d); m_preset = int'(d); m_run = (d != 0); m_exp = 0;
    end else if (m_run && en) begin
      if (m_q > 1) begin
        m_q = m_q - 1;
      end else begin
        pulse = 1;
        if (mode) begin
          m_q = m_preset;
        end else begin
          m_q = 0; m_run = 0; m_exp = 1;
        end
      end
    end
    m_tc = pulse;
  end

  // Continuous compare against the model, away from the active edge.
  always @(negedge clk) begin
    checks++;
    if (int'(q) != m_q || tc !== m_tc || busy !== m_run || done !== m_exp) begin
      failures++;
      $display("[TB] FAIL model t=%0t got q=%0d tc=%b busy=%b done=%b want q=%0d tc=%b busy=%b done=%b",
               $time, q, tc, busy, done, m_q, m_tc, m_run, m_exp);
    end
  end

  task automatic applyStimulus(input logic l, input int dv, input logic e, input logic m);
    load = l;
    d    = WIDTH'(dv);
    en   = e;
    mode = m;
  endtask

  task automatic checkOutput(input string name, input int eq, input logic etc,
                             input logic ebusy, input logic edone);
    checks++;
    if (int'(q) != eq || tc !== etc || busy !== ebusy || done !== edone) begin
      failures++;
      $display("[TB] FAIL %s got q=%0d tc=%b busy=%b done=%b want q=%0d tc=%b busy=%b done=%b",
               name, q, tc, busy, done, eq, etc, ebusy, edone);
    end
  endtask

  task automatic stepCheck(input string name, input int eq, input logic etc,
                           input logic ebusy, input logic edone);
    @(posedge clk);
    #1;
    checkOutput(name, eq, etc, ebusy, edone);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0);
    #12;
    checkOutput("reset", 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // One-shot from 4.
    applyStimulus(1, 4, 1, 0);
    stepCheck("os_load", 4, 0, 1, 0);
    applyStimulus(0, 0, 1, 0);
    stepCheck("os_3", 3, 0, 1, 0);
    stepCheck("os_2", 2, 0, 1, 0);
    stepCheck("os_1", 1, 0, 1, 0);
    stepCheck("os_0", 0, 1, 0, 1);
    stepCheck("os_hold", 0, 0, 0, 1);
    stepCheck("os_hold2", 0, 0, 0, 1);

    // Auto-reload from 3 over nine cycles.
    applyStimulus(1, 3, 1, 1);
    stepCheck("ar_0", 3, 0, 1, 0);
    applyStimulus(0, 0, 1, 1);
    for (int k = 1; k < 9; k++) begin
      stepCheck($sformatf("ar_%0d", k), 3 - (k % 3), (k % 3) == 0, 1, 0);
    end

    // Enable gating: 5,4,4,4,3.
    applyStimulus(1, 5, 1, 0);
    stepCheck("en_load", 5, 0, 1, 0);
    applyStimulus(0, 0, 1, 0); stepCheck("en_a", 4, 0, 1, 0);
    applyStimulus(0, 0, 0, 0); stepCheck("en_b", 4, 0, 1, 0);
    applyStimulus(0, 0, 0, 0); stepCheck("en_c", 4, 0, 1, 0);
    applyStimulus(0, 0, 1, 0); stepCheck("en_d", 3, 0, 1, 0);

    // Load colliding with the terminal event.
    applyStimulus(1, 2, 1, 0); stepCheck("col_load", 2, 0, 1, 0);
    applyStimulus(0, 0, 1, 0); stepCheck("col_1", 1, 0, 1, 0);
    applyStimulus(1, 7, 1, 0); stepCheck("col_7", 7, 0, 1, 0);
    applyStimulus(0, 0, 1, 0); stepCheck("col_6", 6, 0, 1, 0);

    // Asynchronous reset between edges while running at 6.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst", 0, 0, 0, 0);
    #2;
    rst_n = 1'b1;
    stepCheck("post_rst_a", 0, 0, 0, 0);
    stepCheck("post_rst_b", 0, 0, 0, 0);

    // Preset of 1 in auto-reload pulses every enabled cycle.
    applyStimulus(1, 1, 1, 1); stepCheck("p1_load", 1, 0, 1, 0);
    applyStimulus(0, 0, 1, 1);
    stepCheck("p1_a", 1, 1, 1, 0);
    stepCheck("p1_b", 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 1); stepCheck("p1_hold", 1, 0, 1, 0);

    // Load of zero parks in IDLE and ignores en.
    applyStimulus(1, 0, 1, 0); stepCheck("z_load", 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      stepCheck($sformatf("z_%0d", k), 0, 0, 0, 0);
    end

    // Randomized phase checked by the model compare process.
    for (int n = 0; n < 600; n++) begin
      logic l;
      int   dv;
      l  = ($urandom_range(0, 9) == 0);
      dv = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 15));
      applyStimulus(l, dv, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      @(posedge clk); #1;
    end

    applyStimulus(0, 0, 0, 0);
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
